// File: rtl/sram_ring_master.sv
// rtl/sram_ring_master.sv - circular FIFO initiator over the single-port SRAM controller
// One write holding register and one read output register share a single request channel.
module sram_ring_master #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            wr_valid,
  input  logic [15:0]     wr_data,
  output logic            wr_ready,
  output logic            rd_valid,
  output logic [15:0]     rd_data,
  input  logic            rd_ready,
  output logic [ADDR_W:0] level,
  output logic            full,
  output logic            empty,
  input  logic            ctrl_ready,
  input  logic [15:0]     ctrl_rdata,
  output logic            ctrl_start_n,
  output logic            ctrl_rw,
  output logic [15:0]     ctrl_addr,
  output logic [15:0]     ctrl_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic GRANT_W = 1'b0;
  localparam logic GRANT_R = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic              ctrl_start_n_q, ctrl_start_n_d;
  logic              ctrl_rw_q, ctrl_rw_d;
  logic [15:0]       ctrl_addr_q, ctrl_addr_d;
  logic [15:0]       ctrl_wdata_q, ctrl_wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              hold_valid_q, hold_valid_d;
  logic [15:0]       hold_data_q, hold_data_d;
  logic              last_grant_q, last_grant_d;
  logic              discard_q, discard_d;

  logic w_ok;
  logic r_ok;
  logic pick_r;

  assign full     = (level_q == DEPTH);
  assign empty    = (level_q == '0);
  assign wr_ready = !hold_valid_q && !clear;
  assign w_ok     = hold_valid_q && !full;
  assign r_ok     = !rd_valid_q && !empty;

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign level        = level_q;
  assign ctrl_start_n = ctrl_start_n_q;
  assign ctrl_rw      = ctrl_rw_q;
  assign ctrl_addr    = ctrl_addr_q;
  assign ctrl_wdata   = ctrl_wdata_q;

  always_comb begin
    state_d        = state_q;
    ctrl_start_n_d = ctrl_start_n_q;
    ctrl_rw_d      = ctrl_rw_q;
    ctrl_addr_d    = ctrl_addr_q;
    ctrl_wdata_d   = ctrl_wdata_q;
    rd_valid_d     = rd_valid_q;
    rd_data_d      = rd_data_q;
    level_d        = level_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    last_grant_d   = last_grant_q;
    discard_d      = discard_q;
    pick_r         = 1'b0;

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
    if (wr_valid && wr_ready) begin
      hold_valid_d = 1'b1;
      hold_data_d  = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        // A grant alongside clear would use pointers that are about to be zeroed.
        if (ctrl_ready && !clear && (w_ok || r_ok)) begin
          pick_r         = r_ok && (!w_ok || (last_grant_q == GRANT_W));
          last_grant_d   = pick_r ? GRANT_R : GRANT_W;
          ctrl_rw_d      = pick_r;
          ctrl_addr_d    = BASE_ADDR | (pick_r ? 16'(rd_ptr_q) : 16'(wr_ptr_q));
          ctrl_wdata_d   = hold_data_q;
          ctrl_start_n_d = 1'b0;
          state_d        = S_REQ;
        end
      end
      S_REQ: begin
        ctrl_start_n_d = 1'b1;
        state_d        = S_BUSY;
      end
      S_BUSY: begin
        state_d = S_WAIT;
      end
      default: begin
        if (ctrl_ready) begin
          state_d = S_IDLE;
          if (!discard_q) begin
            if (ctrl_rw_q) begin
              rd_data_d  = ctrl_rdata;
              rd_valid_d = 1'b1;
              rd_ptr_d   = rd_ptr_q + PTR_ONE;
              level_d    = level_q - LVL_ONE;
            end else begin
              hold_valid_d = 1'b0;
              wr_ptr_d     = wr_ptr_q + PTR_ONE;
              level_d      = level_q + LVL_ONE;
            end
          end
        end
      end
    endcase

    // A flushed ring must ignore whatever the in-flight transaction returns.
    if (state_d == S_IDLE) begin
      discard_d = 1'b0;
    end else if (clear) begin
      discard_d = 1'b1;
    end

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      hold_valid_d = 1'b0;
      rd_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      ctrl_start_n_q <= 1'b1;
      ctrl_rw_q      <= 1'b1;
      ctrl_addr_q    <= '0;
      ctrl_wdata_q   <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      level_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= '0;
      last_grant_q   <= GRANT_R;
      discard_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctrl_start_n_q <= ctrl_start_n_d;
      ctrl_rw_q      <= ctrl_rw_d;
      ctrl_addr_q    <= ctrl_addr_d;
      ctrl_wdata_q   <= ctrl_wdata_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      level_q        <= level_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      hold_valid_q   <= hold_valid_d;
      hold_data_q    <= hold_data_d;
      last_grant_q   <= last_grant_d;
      discard_q      <= discard_d;
    end
  end

endmodule
